// File: rtl/mux_pipeline_stream.sv
// rtl/mux_pipeline_stream.sv - registered radix-MUX_SIZE N:1 mux tree, one valid/ready stage per level
// Optional MUX_PIPELINE_STREAM_SEL_OUT_EN adds out_sel/out_sel_err carrying each transaction's full select.
module mux_pipeline_stream #(
  parameter int WIDTH       = 8,
  parameter int INPUT_COUNT = 5,
  parameter int MUX_SIZE    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(INPUT_COUNT)-1:0] sel,
  input  logic [WIDTH*INPUT_COUNT-1:0]   in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
  ,
  output logic [$clog2(INPUT_COUNT)-1:0] out_sel,
  output logic                           out_sel_err
`endif
);

  function automatic int units_at(input int lvl);
    int n;
    n = INPUT_COUNT;
    for (int i = 0; i < lvl; i++) n = (n + MUX_SIZE - 1) / MUX_SIZE;
    return n;
  endfunction

  function automatic int calc_stages(input int count);
    int n;
    int s;
    n = count;
    s = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 1) begin
        n = (n + MUX_SIZE - 1) / MUX_SIZE;
        s++;
      end
    end
    return s;
  endfunction

  localparam int STAGES = calc_stages(INPUT_COUNT);
  localparam int LOG_M  = $clog2(MUX_SIZE);
  localparam int SEL_W  = $clog2(INPUT_COUNT);
  localparam int SELP   = STAGES * LOG_M;
  // Every level is presented zero-padded to the widest reach of any unit, so
  // missing and out-of-range lanes read as 0 without bounds checks.
  localparam int LANES  = units_at(1) * MUX_SIZE;

  logic [LANES*WIDTH-1:0] lvl     [STAGES];
  logic [SELP-1:0]        sel_lvl [STAGES];
  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      stage_ready;
  logic                   chain_r;

  if (LANES > INPUT_COUNT) begin : g_pad_in
    assign lvl[0] = {{((LANES - INPUT_COUNT) * WIDTH){1'b0}}, in};
  end else begin : g_nopad_in
    assign lvl[0] = in;
  end
  assign sel_lvl[0] = SELP'(sel);

  // A stage can load when any stage at or after it is empty, or the sink is ready.
  always_comb begin
    chain_r     = out_ready;
    stage_ready = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      chain_r        = chain_r | ~valid_q[s];
      stage_ready[s] = chain_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (stage_ready[0]) valid_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        if (stage_ready[s]) valid_q[s] <= valid_q[s-1];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int UO = units_at(s + 1);

    logic [UO*WIDTH-1:0] data_q;
    logic [UO*WIDTH-1:0] data_d;
    logic [LOG_M-1:0]    sub_sel;

    assign sub_sel = sel_lvl[s][LOG_M-1:0];

    always_comb begin
      data_d = '0;
      for (int j = 0; j < UO; j++) begin
        data_d[j*WIDTH +: WIDTH] = lvl[s][(j * MUX_SIZE + int'(sub_sel)) * WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
      end else if (stage_ready[s]) begin
        data_q <= data_d;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      localparam int RW = SELP - (s + 1) * LOG_M;

      logic [RW-1:0] rsel_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rsel_q <= '0;
        end else if (stage_ready[s]) begin
          rsel_q <= sel_lvl[s][LOG_M +: RW];
        end
      end

      assign lvl[s+1]     = {{((LANES - UO) * WIDTH){1'b0}}, data_q};
      assign sel_lvl[s+1] = {{((s + 1) * LOG_M){1'b0}}, rsel_q};
    end else begin : g_last
      assign out = data_q;
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[STAGES-1];

`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
  logic [SEL_W-1:0]  fsel_q [STAGES];
  logic [STAGES-1:0] ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) fsel_q[s] <= '0;
      ferr_q <= '0;
    end else begin
      if (stage_ready[0]) begin
        fsel_q[0] <= sel;
        ferr_q[0] <= (32'(sel) >= INPUT_COUNT);
      end
      for (int s = 1; s < STAGES; s++) begin
        if (stage_ready[s]) begin
          fsel_q[s] <= fsel_q[s-1];
          ferr_q[s] <= ferr_q[s-1];
        end
      end
    end
  end

  assign out_sel     = fsel_q[STAGES-1];
  assign out_sel_err = ferr_q[STAGES-1];
`endif

endmodule

// File: tb/tb_mux_pipeline_stream.sv
// tb/tb_mux_pipeline_stream.sv - directed and scoreboarded bench for mux_pipeline_stream
module tb_mux_pipeline_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   sel;
  logic [39:0]  in_vec;
  logic [7:0]   out_data;
  logic         in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]   sel4;
  logic [127:0] in_vec4;
  logic [7:0]   out4;
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
  logic [2:0]   out_sel;
  logic         out_sel_err;
  logic [3:0]   out_sel4;
  logic         out_sel_err4;
`endif

  int         vectors = 0;
  int         miscompares = 0;
  int         acc;
  logic       hold_pending;
  logic [7:0] held_val;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  mux_pipeline_stream #(.WIDTH(8), .INPUT_COUNT(5), .MUX_SIZE(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .in(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_data)
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
    , .out_sel(out_sel), .out_sel_err(out_sel_err)
`endif
  );

  mux_pipeline_stream #(.WIDTH(8), .INPUT_COUNT(16), .MUX_SIZE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .sel(sel4), .in(in_vec4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out4)
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
    , .out_sel(out_sel4), .out_sel_err(out_sel_err4)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp5(input int s);
    return (s < 5) ? 8'(8'h11 * (s + 1)) : 8'h00;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = '0;
    in_vec = 40'h55_44_33_22_11;
    in_valid4 = 1'b0; out_ready4 = 1'b1; sel4 = '0; in_vec4 = '0;
    tick(); tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid4", out_valid4, 0);
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
    check_eq("rst_out_sel", out_sel, 0);
    check_eq("rst_out_sel_err", out_sel_err, 0);
`endif
    rst = 1'b0;
    tick();

    // stream sel 0..4, output starts 3 edges after the first accept
    for (int k = 1; k <= 9; k++) begin
      in_valid = (k <= 5);
      sel = (k <= 5) ? 3'(k - 1) : 3'd0;
      #1;
      check_eq("str_in_ready", in_ready, 1);
      tick();
      if (k >= 3 && k <= 7) begin
        check_eq("str_out_valid", out_valid, 1);
        check_eq("str_out", out_data, exp5(k - 3));
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
        check_eq("str_out_sel", out_sel, k - 3);
        check_eq("str_out_sel_err", out_sel_err, 0);
`endif
      end else begin
        check_eq("str_out_idle", out_valid, 0);
      end
    end

    // backpressure: only three accepts fit, head holds 11
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      sel = 3'(acc);
      #1;
      check_eq("bp_in_ready", in_ready, (c < 3));
      if (in_ready) acc++;
      tick();
      if (c >= 2) begin
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_out_hold", out_data, 8'h11);
      end
    end
    check_eq("bp_accepts", acc, 3);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("bp_rel_valid", out_valid, 1);
      check_eq("bp_rel_out", out_data, exp5(k));
      tick();
    end
    check_eq("bp_rel_empty", out_valid, 0);

    // bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd2;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; sel = 3'd4;
    tick();
    in_valid = 1'b0;
    check_eq("bub_out_a", out_data, 8'h33);
    tick(); tick();
    check_eq("bub_out_valid", out_valid, 1);
    check_eq("bub_out_hold", out_data, 8'h33);
    check_eq("bub_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    check_eq("bub_b_valid", out_valid, 1);
    check_eq("bub_out_b", out_data, 8'h55);
    tick();
    check_eq("bub_empty", out_valid, 0);

    // out-of-range select yields zero data but is still delivered
    in_valid = 1'b1; sel = 3'd7;
    tick();
    in_valid = 1'b0;
    check_eq("oor_early", out_valid, 0);
    tick(); tick();
    check_eq("oor_valid", out_valid, 1);
    check_eq("oor_out", out_data, 8'h00);
`ifdef MUX_PIPELINE_STREAM_SEL_OUT_EN
    check_eq("oor_out_sel", out_sel, 7);
    check_eq("oor_out_sel_err", out_sel_err, 1);
`endif
    tick();
    check_eq("oor_empty", out_valid, 0);

    // asynchronous reset with three transactions in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("ar_pre_valid", out_valid, 1);
    check_eq("ar_pre_out", out_data, 8'h11);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_out_valid", out_valid, 0);
    check_eq("ar_out", out_data, 0);
    check_eq("ar_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("ar_no_stale", out_valid, 0);
    end

    // radix-4, 16 inputs: latency 2
    for (int k = 0; k < 16; k++) in_vec4[k*8 +: 8] = 8'(k * 16 + 3);
    out_ready4 = 1'b1; in_valid4 = 1'b1; sel4 = 4'd9;
    tick();
    in_valid4 = 1'b0;
    check_eq("r4_lat1", out_valid4, 0);
    tick();
    check_eq("r4_lat2_valid", out_valid4, 1);
    check_eq("r4_lat2_out", out4, 8'h93);
    tick();
    check_eq("r4_empty", out_valid4, 0);

    // radix-4 random traffic against a scoreboard
    hold_pending = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid4  = 1'($urandom_range(0, 1));
      sel4       = 4'($urandom);
      in_vec4    = {$urandom, $urandom, $urandom, $urandom};
      out_ready4 = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_pending) begin
        check_eq("sw_hold_valid", out_valid4, 1);
        check_eq("sw_hold_out", out4, held_val);
      end
      if (out_valid4 && out_ready4) begin
        check_eq("sw_sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) check_eq("sw_out", out4, sb.pop_front());
      end
      if (in_valid4 && in_ready4) sb.push_back(in_vec4[int'(sel4)*8 +: 8]);
      hold_pending = out_valid4 && !out_ready4;
      held_val     = out4;
      tick();
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid4) begin
        check_eq("sw_drain_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) check_eq("sw_drain_out", out4, sb.pop_front());
      end
      tick();
    end
    check_eq("sw_sb_empty", sb.size(), 0);
    check_eq("sw_final_idle", out_valid4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
